command_receiver: RTL and testbench

//  Host-side UART command decoder, directly upstream of the transmitter FSM. Consumes bytes from
//  the UART receiver, parses framed commands 'd' <cmd> [payload] '4', and drives the control state
//  the transmitter and hash cores read: chip enable, a sticky ping-request flag and a seed nonce.

---
 rtl/cmd_pkg.sv | 24 ++
 rtl/rx_timeout.sv | 29 ++
 rtl/command_receiver.sv | 129 ++++++++++++
 tb/tb_command_receiver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared constants and state type for the UART command path.
// The footer byte is also consumed by the transmitter.
package cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD,
    ST_FOOTER
  } state_t;

  localparam logic [7:0] HDR       = 8'd100;
  localparam logic [7:0] FTR       = 8'd52;
  localparam logic [7:0] CMD_EN    = 8'd101;
  localparam logic [7:0] CMD_DIS   = 8'd115;
  localparam logic [7:0] CMD_PING  = 8'd112;
  localparam logic [7:0] CMD_NONCE = 8'd110;

  // Commands that carry no payload and go straight to the footer.
  function automatic logic is_simple_cmd(input logic [7:0] b);
    return (b == CMD_EN) || (b == CMD_DIS) || (b == CMD_PING);
  endfunction

endpackage

// File: rtl/rx_timeout.sv
// Inter-byte idle counter: flags a stalled frame after TIMEOUT_CYCLES quiet cycles.
module rx_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_cnt;

  // A byte arriving on the terminal count cycle suppresses the expiry.
  assign o_expired = i_enable && !i_clear && (r_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable || o_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/command_receiver.sv
// Parses framed UART commands 'd' <cmd> [payload] '4' and drives chip enable,
// ping request and seed nonce state for the transmitter and hash cores.
module command_receiver
  import cmd_pkg::*;
#(
  parameter int NONCE_BYTES    = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   rx_new_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   reset_ping_waiting_i,
  output logic                   chip_enabled_o,
  output logic                   ping_waiting_o,
  output logic [8*NONCE_BYTES-1:0] seed_nonce_o,
  output logic                   seed_valid_o,
  output logic                   frame_error_o
);

  localparam int NW = 8 * NONCE_BYTES;
  localparam int BW = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;

  state_t          r_state, w_state_next;
  logic [7:0]      r_cmd, w_cmd_next;
  logic [BW-1:0]   r_byte_cnt, w_byte_cnt_next;
  logic [NW-1:0]   r_stage, w_stage_next;
  logic            w_commit;
  logic            w_error;
  logic            w_expired;

  rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .i_clear   (rx_new_i),
    .i_enable  (r_state != ST_IDLE),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_next    = r_state;
    w_cmd_next      = r_cmd;
    w_byte_cnt_next = r_byte_cnt;
    w_stage_next    = r_stage;
    w_commit        = 1'b0;
    w_error         = 1'b0;
    if (w_expired) begin
      w_state_next = ST_IDLE;
      w_error      = 1'b1;
    end else if (rx_new_i) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data_i == HDR) w_state_next = ST_CMD;
        end
        ST_CMD: begin
          if (is_simple_cmd(rx_data_i)) begin
            w_cmd_next   = rx_data_i;
            w_state_next = ST_FOOTER;
          end else if (rx_data_i == CMD_NONCE) begin
            w_cmd_next      = rx_data_i;
            w_byte_cnt_next = BW'(NONCE_BYTES - 1);
            w_state_next    = ST_PAYLOAD;
          end else begin
            w_state_next = ST_IDLE;
            w_error      = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          // Payload bytes are opaque; header/footer values are plain data here.
          w_stage_next = NW'({r_stage, rx_data_i});
          if (r_byte_cnt == '0) begin
            w_state_next = ST_FOOTER;
          end else begin
            w_byte_cnt_next = r_byte_cnt - 1'b1;
          end
        end
        ST_FOOTER: begin
          w_state_next = ST_IDLE;
          if (rx_data_i == FTR) w_commit = 1'b1;
          else                  w_error  = 1'b1;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state        <= ST_IDLE;
      r_cmd          <= '0;
      r_byte_cnt     <= '0;
      r_stage        <= '0;
      chip_enabled_o <= 1'b0;
      ping_waiting_o <= 1'b0;
      seed_nonce_o   <= '0;
      seed_valid_o   <= 1'b0;
      frame_error_o  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cmd         <= w_cmd_next;
      r_byte_cnt    <= w_byte_cnt_next;
      r_stage       <= w_stage_next;
      seed_valid_o  <= 1'b0;
      frame_error_o <= w_error;
      if (w_commit) begin
        case (r_cmd)
          CMD_EN:    chip_enabled_o <= 1'b1;
          CMD_DIS:   chip_enabled_o <= 1'b0;
          CMD_NONCE: begin
            seed_nonce_o <= r_stage;
            seed_valid_o <= 1'b1;
          end
          default: ;
        endcase
      end
      // A new ping request outranks a simultaneous clear from the transmitter.
      if (w_commit && (r_cmd == CMD_PING)) begin
        ping_waiting_o <= 1'b1;
      end else if (reset_ping_waiting_i) begin
        ping_waiting_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_command_receiver.sv
// Table-driven frame vectors with an expected-result queue, plus hand-written
// sequences for ping races, timeout and mid-frame reset.
module tb_command_receiver;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         rx_new_i;
  logic [7:0]   rx_data_i;
  logic         reset_ping_waiting_i;
  logic         chip_enabled_o;
  logic         ping_waiting_o;
  logic [127:0] seed_nonce_o;
  logic         seed_valid_o;
  logic         frame_error_o;

  always #5 clk_i = ~clk_i;

  command_receiver #(
    .NONCE_BYTES(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i                (clk_i),
    .rst_n_i              (rst_n_i),
    .rx_new_i             (rx_new_i),
    .rx_data_i            (rx_data_i),
    .reset_ping_waiting_i (reset_ping_waiting_i),
    .chip_enabled_o       (chip_enabled_o),
    .ping_waiting_o       (ping_waiting_o),
    .seed_nonce_o         (seed_nonce_o),
    .seed_valid_o         (seed_valid_o),
    .frame_error_o        (frame_error_o)
  );

  typedef struct packed {
    logic         en;
    logic         ping;
    logic         valid;
    logic         err;
    logic [127:0] nonce;
  } exp_t;

  typedef struct {
    int               len;
    logic [0:19][7:0] b;
    exp_t             exp;
  } vec_t;

  localparam logic [127:0] N_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] N_BAD  = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
  localparam logic [127:0] N_HF   = {8{16'h6434}};
  localparam logic [127:0] N_HAND = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[10];
  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mke(input logic en, ping, valid, err, input logic [127:0] nonce);
    exp_t e;
    e.en = en; e.ping = ping; e.valid = valid; e.err = err; e.nonce = nonce;
    return e;
  endfunction

  function automatic vec_t simple(input logic [7:0] c0, c1, c2, input int len, input exp_t e);
    vec_t v;
    v.len = len; v.b = '0;
    v.b[0] = c0; v.b[1] = c1; v.b[2] = c2;
    v.exp = e;
    return v;
  endfunction

  function automatic vec_t nonce_frame(input logic [127:0] payload, input logic [7:0] ftr, input exp_t e);
    vec_t v;
    v.len = 19; v.b = '0;
    v.b[0] = 8'h64; v.b[1] = 8'h6e;
    for (int i = 0; i < 16; i++) v.b[2+i] = payload[127-8*i -: 8];
    v.b[18] = ftr;
    v.exp = e;
    return v;
  endfunction

  // Called on a negedge; returns on the negedge after the byte is sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_new_i  = 1'b1;
    rx_data_i = b;
    @(negedge clk_i);
    rx_new_i  = 1'b0;
  endtask

  task automatic send3(input logic [7:0] c0, c1, c2);
    send_byte(c0); send_byte(c1); send_byte(c2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   first;

    vecs[0] = simple(8'h64, 8'h65, 8'h34, 3, mke(1, 0, 0, 0, '0));
    vecs[1] = simple(8'h64, 8'h73, 8'h34, 3, mke(0, 0, 0, 0, '0));
    vecs[2] = simple(8'h64, 8'h65, 8'h34, 3, mke(1, 0, 0, 0, '0));
    vecs[3] = simple(8'h64, 8'h70, 8'h34, 3, mke(1, 1, 0, 0, '0));
    vecs[4] = nonce_frame(N_SEQ, 8'h34, mke(1, 1, 1, 0, N_SEQ));
    vecs[5] = nonce_frame(N_BAD, 8'h78, mke(1, 1, 0, 1, N_SEQ));
    vecs[6] = simple(8'h64, 8'h7a, 8'h00, 2, mke(1, 1, 0, 1, N_SEQ));
    vecs[7] = simple(8'h78, 8'h79, 8'h00, 2, mke(1, 1, 0, 0, N_SEQ));
    vecs[8] = nonce_frame(N_HF, 8'h34, mke(1, 1, 1, 0, N_HF));
    vecs[9] = simple(8'h64, 8'h65, 8'h78, 3, mke(1, 1, 0, 1, N_HF));

    rst_n_i = 1'b0; rx_new_i = 1'b0; rx_data_i = '0; reset_ping_waiting_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_en", chip_enabled_o, 0);
    chk("rst_ping", ping_waiting_o, 0);
    chk("rst_nonce", seed_nonce_o, 0);
    chk("rst_valid", seed_valid_o, 0);
    chk("rst_err", frame_error_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    for (int k = 0; k < 10; k++) begin
      sb.push_back(vecs[k].exp);
      for (int i = 0; i < vecs[k].len; i++) send_byte(vecs[k].b[i]);
      e = sb.pop_front();
      chk($sformatf("v%0d_en", k), chip_enabled_o, e.en);
      chk($sformatf("v%0d_ping", k), ping_waiting_o, e.ping);
      chk($sformatf("v%0d_valid", k), seed_valid_o, e.valid);
      chk($sformatf("v%0d_err", k), frame_error_o, e.err);
      chk($sformatf("v%0d_nonce", k), seed_nonce_o, e.nonce);
      $display("vec %0d len %0d en=%0b ping=%0b valid=%0b err=%0b", k, vecs[k].len,
               chip_enabled_o, ping_waiting_o, seed_valid_o, frame_error_o);
    end

    reset_ping_waiting_i = 1'b1;
    @(negedge clk_i);
    reset_ping_waiting_i = 1'b0;
    chk("ping_clear", ping_waiting_o, 0);
    $display("ping clear ping=%0b", ping_waiting_o);

    send_byte(8'h64); send_byte(8'h70);
    rx_new_i = 1'b1; rx_data_i = 8'h34; reset_ping_waiting_i = 1'b1;
    @(negedge clk_i);
    rx_new_i = 1'b0; reset_ping_waiting_i = 1'b0;
    chk("ping_set_wins", ping_waiting_o, 1);
    $display("ping commit+clear same cycle ping=%0b", ping_waiting_o);

    send_byte(8'h64); send_byte(8'h6e);
    for (int i = 0; i < 16; i++) send_byte(N_HAND[127-8*i -: 8]);
    send_byte(8'h34);
    chk("hand_valid", seed_valid_o, 1);
    chk("hand_nonce", seed_nonce_o, N_HAND);
    @(negedge clk_i);
    chk("hand_valid_one_pulse", seed_valid_o, 0);
    $display("nonce load nonce=%h", seed_nonce_o);

    send3(8'h64, 8'h73, 8'h34);
    chk("disable", chip_enabled_o, 0);
    $display("disable en=%0b", chip_enabled_o);

    send_byte(8'h64);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      if (frame_error_o && first == 0) first = k;
    end
    chk("timeout_cycle", first, 8);
    send_byte(8'h65); send_byte(8'h34);
    chk("timeout_no_commit_en", chip_enabled_o, 0);
    chk("timeout_no_commit_err", frame_error_o, 0);
    $display("timeout error after %0d idle cycles", first);

    send3(8'h64, 8'h65, 8'h34);
    send3(8'h64, 8'h70, 8'h34);
    chk("pre_rst_en", chip_enabled_o, 1);
    send_byte(8'h64); send_byte(8'h6e);
    for (int i = 0; i < 5; i++) send_byte(8'h11);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_rst_en", chip_enabled_o, 0);
    chk("async_rst_ping", ping_waiting_o, 0);
    chk("async_rst_nonce", seed_nonce_o, 0);
    chk("async_rst_valid", seed_valid_o, 0);
    chk("async_rst_err", frame_error_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    send3(8'h64, 8'h65, 8'h34);
    chk("post_rst_en", chip_enabled_o, 1);
    chk("post_rst_nonce", seed_nonce_o, 0);
    $display("reset mid-payload then enable en=%0b", chip_enabled_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
